// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester-side and FIFO-write-side signals of the write-port arbiter
//  req_valid/req_data/req_last/req_ready : per-requester beat handshake
//  wfull/winc/wdata                      : async FIFO write port (wclk domain)
//  grant_id/busy                         : arbitration status
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
);
    localparam int IW = $clog2(NREQ);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [IW-1:0]         grant_id;
    logic                  busy;
    modport master (
        output req_valid, req_data, req_last, wfull,
        input  req_ready, winc, wdata, grant_id, busy
    );
    modport slave (
        input  req_valid, req_data, req_last, wfull,
        output req_ready, winc, wdata, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one async FIFO write port among NREQ requesters
//  wclk : write-domain clock
//  wrst : synchronous active-high reset
//  bus  : fifo_wr_arbiter_if.slave (requester handshake, FIFO write port, grant_id/busy status)
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBURST = 16
) (
    input logic              wclk,
    input logic              wrst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(MAXBURST + 1);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        state;
    logic [IW-1:0] rr_ptr, grant_id, pick, idx, next_ptr;
    logic [BW-1:0] beat_cnt;
    logic          xfer, last_beat;
    // Scan downward in priority so the requester closest to rr_ptr is written last and wins.
    always_comb begin
        pick = rr_ptr;
        idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = IW'((int'(rr_ptr) + i) % NREQ);
            if (bus.req_valid[idx]) pick = idx;
        end
    end
    assign xfer          = (state == GRANT) & bus.req_valid[grant_id] & ~bus.wfull;
    assign last_beat     = bus.req_last[grant_id] | (beat_cnt == BW'(MAXBURST - 1));
    assign next_ptr      = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    assign bus.winc      = xfer;
    assign bus.req_ready = NREQ'(xfer) << grant_id;
    assign bus.wdata     = bus.req_data[int'(grant_id) * DSIZE +: DSIZE];
    assign bus.grant_id  = grant_id;
    assign bus.busy      = (state == GRANT);
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            if (|bus.req_valid) begin
                grant_id <= pick;
                beat_cnt <= '0;
                state    <= GRANT;
            end
        end else if (xfer) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            if (last_beat) begin
                rr_ptr <= next_ptr;
                state  <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed table-driven and hand-sequenced checks of fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    logic wclk = 1'b0;
    logic wrst;
    int   n_cmp = 0;
    int   n_bad = 0;
    fifo_wr_arbiter_if #(.NREQ(4), .DSIZE(8)) bus ();
    fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .MAXBURST(16)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus)
    );
    always #5 wclk = ~wclk;
    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       wfull;
        logic       winc;
        logic [3:0] ready;
        logic [7:0] wdata;
        logic [1:0] grant;
        logic       busy;
    } vec_t;
    vec_t tbl [13];
    task automatic tick();
        @(negedge wclk);
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic chk_idle(input string nm, input logic [1:0] g);
        chk({nm, ".winc"}, 32'(bus.winc), 0);
        chk({nm, ".ready"}, 32'(bus.req_ready), 0);
        chk({nm, ".busy"}, 32'(bus.busy), 0);
        chk({nm, ".grant"}, 32'(bus.grant_id), 32'(g));
    endtask
    task automatic chk_beat(input string nm, input logic [3:0] r, input logic [7:0] d, input logic [1:0] g);
        chk({nm, ".winc"}, 32'(bus.winc), 1);
        chk({nm, ".ready"}, 32'(bus.req_ready), 32'(r));
        chk({nm, ".wdata"}, 32'(bus.wdata), 32'(d));
        chk({nm, ".grant"}, 32'(bus.grant_id), 32'(g));
        chk({nm, ".busy"}, 32'(bus.busy), 1);
    endtask
    task automatic chk_stall(input string nm, input logic [1:0] g);
        chk({nm, ".winc"}, 32'(bus.winc), 0);
        chk({nm, ".ready"}, 32'(bus.req_ready), 0);
        chk({nm, ".busy"}, 32'(bus.busy), 1);
        chk({nm, ".grant"}, 32'(bus.grant_id), 32'(g));
    endtask
    task automatic do_reset();
        wrst = 1'b1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.wfull     = 1'b0;
        tick();
        wrst = 1'b0;
    endtask
    initial begin
        // round robin with 1-beat packets; a wfull stall on the last grant
        tbl[0]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 8'hA0, 2'd0, 1'b0};
        tbl[1]  = '{4'hF, 4'hF, 1'b0, 1'b1, 4'h1, 8'hA0, 2'd0, 1'b1};
        tbl[2]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 8'hA0, 2'd0, 1'b0};
        tbl[3]  = '{4'hF, 4'hF, 1'b0, 1'b1, 4'h2, 8'hB1, 2'd1, 1'b1};
        tbl[4]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 8'hB1, 2'd1, 1'b0};
        tbl[5]  = '{4'hF, 4'hF, 1'b0, 1'b1, 4'h4, 8'hC2, 2'd2, 1'b1};
        tbl[6]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 8'hC2, 2'd2, 1'b0};
        tbl[7]  = '{4'hF, 4'hF, 1'b0, 1'b1, 4'h8, 8'hD3, 2'd3, 1'b1};
        tbl[8]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 8'hD3, 2'd3, 1'b0};
        tbl[9]  = '{4'hF, 4'hF, 1'b0, 1'b1, 4'h1, 8'hA0, 2'd0, 1'b1};
        tbl[10] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 8'hA0, 2'd0, 1'b0};
        tbl[11] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 8'hB1, 2'd1, 1'b1};
        tbl[12] = '{4'hF, 4'hF, 1'b0, 1'b1, 4'h2, 8'hB1, 2'd1, 1'b1};
        wrst          = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_last  = 4'hF;
        bus.wfull     = 1'b0;
        bus.req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        for (int c = 0; c < 2; c++) begin
            tick();
            #1 chk_idle($sformatf("reset%0d", c), 2'd0);
        end
        tick();
        wrst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            bus.req_valid = tbl[i].valid;
            bus.req_last  = tbl[i].last;
            bus.wfull     = tbl[i].wfull;
            #1;
            chk($sformatf("rr%0d.winc", i), 32'(bus.winc), 32'(tbl[i].winc));
            chk($sformatf("rr%0d.ready", i), 32'(bus.req_ready), 32'(tbl[i].ready));
            chk($sformatf("rr%0d.wdata", i), 32'(bus.wdata), 32'(tbl[i].wdata));
            chk($sformatf("rr%0d.grant", i), 32'(bus.grant_id), 32'(tbl[i].grant));
            chk($sformatf("rr%0d.busy", i), 32'(bus.busy), 32'(tbl[i].busy));
            tick();
        end
        // burst lock: req0 sends 5 beats while req1 waits
        do_reset();
        bus.req_valid = 4'b0011;
        bus.req_data  = {8'hD3, 8'hC2, 8'hB1, 8'h00};
        #1 chk_idle("lock.idle0", 2'd0);
        tick();
        for (int k = 1; k <= 5; k++) begin
            bus.req_data[7:0] = 8'(k);
            bus.req_last[0]   = (k == 5);
            #1 chk_beat($sformatf("lock.beat%0d", k), 4'h1, 8'(k), 2'd0);
            tick();
        end
        bus.req_valid = 4'b0010;
        bus.req_last  = 4'b0010;
        #1 chk_idle("lock.gap", 2'd0);
        tick();
        #1 chk_beat("lock.req1", 4'h2, 8'hB1, 2'd1);
        tick();
        // backpressure: 3 stalled cycles mid-burst
        do_reset();
        bus.req_valid = 4'b0001;
        #1 chk_idle("bp.idle", 2'd0);
        tick();
        for (int k = 1; k <= 2; k++) begin
            bus.req_data[7:0] = 8'(8'h30 + k);
            #1 chk_beat($sformatf("bp.beat%0d", k), 4'h1, 8'(8'h30 + k), 2'd0);
            tick();
        end
        bus.req_data[7:0] = 8'h33;
        bus.wfull = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk_stall($sformatf("bp.stall%0d", c), 2'd0);
            chk($sformatf("bp.stall%0d.beat_cnt", c), 32'(dut.beat_cnt), 2);
            tick();
        end
        bus.wfull = 1'b0;
        for (int k = 3; k <= 4; k++) begin
            bus.req_data[7:0] = 8'(8'h30 + k);
            bus.req_last[0]   = (k == 4);
            #1 chk_beat($sformatf("bp.beat%0d", k), 4'h1, 8'(8'h30 + k), 2'd0);
            tick();
        end
        bus.req_valid = '0;
        #1 chk_idle("bp.end", 2'd0);
        tick();
        // MAXBURST cut: req2 streams 20 beats, req3 gets in between
        do_reset();
        bus.req_valid = 4'b1100;
        bus.req_last  = 4'b1000;
        bus.req_data[31:24] = 8'hEE;
        #1 chk_idle("mb.idle0", 2'd0);
        tick();
        for (int k = 1; k <= 16; k++) begin
            bus.req_data[23:16] = 8'(8'h40 + k);
            #1 chk_beat($sformatf("mb.beat%0d", k), 4'h4, 8'(8'h40 + k), 2'd2);
            if (k == 16) chk("mb.beat_cnt_max", 32'(dut.beat_cnt), 15);
            tick();
        end
        bus.req_data[23:16] = 8'h51;
        #1 chk_idle("mb.cut", 2'd2);
        tick();
        #1 chk_beat("mb.req3", 4'h8, 8'hEE, 2'd3);
        tick();
        bus.req_valid = 4'b0100;
        #1 chk_idle("mb.gap2", 2'd3);
        tick();
        for (int k = 17; k <= 20; k++) begin
            bus.req_data[23:16] = 8'(8'h40 + k);
            bus.req_last[2]     = (k == 20);
            #1 chk_beat($sformatf("mb.beat%0d", k), 4'h4, 8'(8'h40 + k), 2'd2);
            tick();
        end
        bus.req_valid = '0;
        #1 chk_idle("mb.end", 2'd2);
        tick();
        // reset mid-burst after 3 beats
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_last  = '0;
        bus.req_data[7:0] = 8'hA0;
        #1 chk_idle("rst.idle", 2'd0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            bus.req_data[15:8] = 8'(8'h60 + k);
            #1 chk_beat($sformatf("rst.beat%0d", k), 4'h2, 8'(8'h60 + k), 2'd1);
            tick();
        end
        wrst = 1'b1;
        bus.req_valid = 4'b0011;
        tick();
        wrst = 1'b0;
        #1 chk_idle("rst.after", 2'd0);
        chk("rst.rr_ptr", 32'(dut.rr_ptr), 0);
        tick();
        #1 chk_beat("rst.regrant", 4'h1, 8'hA0, 2'd0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
